// File: rtl/pacman_gfx_pkg.sv
// Shared graphics constants for the maze renderer: sprite codes, palette,
// screen limits and the renderer state encoding.
package pacman_gfx_pkg;

    localparam logic [2:0] SPR_EMPTY     = 3'd0;
    localparam logic [2:0] SPR_BIG_ORB   = 3'd1;
    localparam logic [2:0] SPR_SMALL_ORB = 3'd2;
    localparam logic [2:0] SPR_WALL      = 3'd3;
    localparam logic [2:0] SPR_DOOR      = 3'd4;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_GREY  = 3'b010;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_DRAW,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/map_tile_renderer_tile_sprite_gen.sv
// Combinational sprite rasteriser: maps a sprite type and an in-tile pixel
// position to an opaque pixel colour (off pixels are black).
module tile_sprite_gen
    import pacman_gfx_pkg::*;
#(
    parameter int TILE_SIZE = 5
) (
    input  logic [2:0] sprite_type,
    input  logic [2:0] px,
    input  logic [2:0] py,
    output logic       pixel_on,
    output logic [2:0] color
);

    localparam logic [2:0] CENTRE   = 3'((TILE_SIZE - 1) / 2);
    localparam logic [2:0] SMALL_RD = 3'(TILE_SIZE / 5);

    logic [2:0] dx;
    logic [2:0] dy;
    logic [3:0] dsum;
    logic [2:0] on_color;

    always_comb begin
        dx       = (px >= CENTRE) ? (px - CENTRE) : (CENTRE - px);
        dy       = (py >= CENTRE) ? (py - CENTRE) : (CENTRE - py);
        dsum     = {1'b0, dx} + {1'b0, dy};
        pixel_on = 1'b0;
        on_color = COL_BLACK;
        case (sprite_type)
            SPR_BIG_ORB: begin
                pixel_on = (dsum <= {1'b0, CENTRE});
                on_color = COL_WHITE;
            end
            SPR_SMALL_ORB: begin
                pixel_on = (dx <= SMALL_RD) && (dy <= SMALL_RD);
                on_color = COL_WHITE;
            end
            SPR_WALL: begin
                pixel_on = 1'b1;
                on_color = COL_BLUE;
            end
            SPR_DOOR: begin
                pixel_on = 1'b1;
                on_color = COL_GREY;
            end
            default: begin
                pixel_on = 1'b0;
                on_color = COL_BLACK;
            end
        endcase
        color = pixel_on ? on_color : COL_BLACK;
    end

endmodule

// File: rtl/map_tile_renderer.sv
// Tile-map renderer: walks the map (whole frame or one dirty tile), fetches
// each tile's sprite from the map store and streams opaque pixels to the VGA port.
module map_tile_renderer
    import pacman_gfx_pkg::*;
#(
    parameter int MAP_W     = 21,
    parameter int MAP_H     = 21,
    parameter int TILE_SIZE = 5,
    parameter int ORIGIN_X  = 1,
    parameter int ORIGIN_Y  = 1
) (
    input  logic       clock_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       single_mode,
    input  logic [4:0] tile_x_in,
    input  logic [4:0] tile_y_in,
    output logic       busy,
    output logic       done,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    input  logic [2:0] sprite_type,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_color
);

    if (MAP_W < 1 || MAP_W > 31 || MAP_H < 1 || MAP_H > 31 ||
        TILE_SIZE < 3 || TILE_SIZE > 7 ||
        ORIGIN_X + MAP_W * TILE_SIZE > SCREEN_W ||
        ORIGIN_Y + MAP_H * TILE_SIZE > SCREEN_H) begin : g_geometry_check
        $error("map_tile_renderer: map geometry does not fit the screen");
    end

    localparam logic [4:0] MAP_W5 = 5'(MAP_W);
    localparam logic [4:0] MAP_H5 = 5'(MAP_H);
    localparam logic [4:0] LAST_X = 5'(MAP_W - 1);
    localparam logic [4:0] LAST_Y = 5'(MAP_H - 1);
    localparam logic [2:0] T_LAST = 3'(TILE_SIZE - 1);

    state_e     state_q, state_d;
    logic       single_q, single_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] map_x_q, map_x_d;
    logic [4:0] map_y_q, map_y_d;
    logic [2:0] sprite_q, sprite_d;
    logic [2:0] px_q, px_d;
    logic [2:0] py_q, py_d;
    logic       vga_plot_q, vga_plot_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_color_q, vga_color_d;

    logic       pix_on;
    logic [2:0] pix_color;
    logic [8:0] pix_x;
    logic [8:0] pix_y;

    tile_sprite_gen #(.TILE_SIZE(TILE_SIZE)) u_sprite (
        .sprite_type(sprite_q),
        .px         (px_q),
        .py         (py_q),
        .pixel_on   (pix_on),
        .color      (pix_color)
    );

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            single_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            sprite_q    <= '0;
            px_q        <= '0;
            py_q        <= '0;
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
        end else begin
            state_q     <= state_d;
            single_q    <= single_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            sprite_q    <= sprite_d;
            px_q        <= px_d;
            py_q        <= py_d;
            vga_plot_q  <= vga_plot_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        single_d    = single_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        map_x_d     = map_x_q;
        map_y_d     = map_y_q;
        sprite_d    = sprite_q;
        px_d        = px_q;
        py_d        = py_q;
        vga_plot_d  = 1'b0;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        pix_x = 9'(ORIGIN_X) + 9'(map_x_q) * 9'(TILE_SIZE) + {6'b0, px_q};
        pix_y = 9'(ORIGIN_Y) + 9'(map_y_q) * 9'(TILE_SIZE) + {6'b0, py_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    single_d = single_mode;
                    busy_d   = 1'b1;
                    if (single_mode && (tile_x_in >= MAP_W5 || tile_y_in >= MAP_H5)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_FETCH;
                        map_x_d = single_mode ? tile_x_in : '0;
                        map_y_d = single_mode ? tile_y_in : '0;
                    end
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                sprite_d = sprite_type;
                px_d     = '0;
                py_d     = '0;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                vga_plot_d  = 1'b1;
                vga_x_d     = pix_x[7:0];
                vga_y_d     = pix_y[6:0];
                vga_color_d = pix_color;
                if (px_q != T_LAST) begin
                    px_d = px_q + 3'd1;
                end else begin
                    px_d = '0;
                    if (py_q != T_LAST) begin
                        py_d = py_q + 3'd1;
                    end else if (single_q || (map_x_q == LAST_X && map_y_q == LAST_Y)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        // Next tile's address goes out on the same edge the last pixel is registered.
                        state_d = ST_FETCH;
                        if (map_x_q == LAST_X) begin
                            map_x_d = '0;
                            map_y_d = map_y_q + 5'd1;
                        end else begin
                            map_x_d = map_x_q + 5'd1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign vga_plot  = vga_plot_q;
    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;

endmodule

// File: tb/tb_map_tile_renderer.sv
// Bench for map_tile_renderer: cycle-accurate plot/busy/done model built from
// the map contents and sprite rules, plus literal pixel and timing expectations.
module tb_map_tile_renderer;

    localparam int T   = 5;
    localparam int W   = 21;
    localparam int H   = 21;
    localparam int OX  = 1;
    localparam int OY  = 1;
    localparam int TPC = T * T + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       start, single_mode;
    logic [4:0] tile_x_in, tile_y_in;
    logic       busy, done, vga_plot;
    logic [4:0] map_x, map_y;
    logic [2:0] sprite_type, vga_color;
    logic [7:0] vga_x;
    logic [6:0] vga_y;

    logic       start7, single7;
    logic [4:0] tx7, ty7, mx7, my7;
    logic       busy7, done7, plot7;
    logic [2:0] spr7, col7;
    logic [7:0] vx7;
    logic [6:0] vy7;

    map_tile_renderer #(.MAP_W(W), .MAP_H(H), .TILE_SIZE(T), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clock_50(clk), .resetn(resetn), .start(start), .single_mode(single_mode),
        .tile_x_in(tile_x_in), .tile_y_in(tile_y_in), .busy(busy), .done(done),
        .map_x(map_x), .map_y(map_y), .sprite_type(sprite_type), .vga_plot(vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color)
    );

    map_tile_renderer #(.MAP_W(16), .MAP_H(16), .TILE_SIZE(7), .ORIGIN_X(1), .ORIGIN_Y(1)) dut7 (
        .clock_50(clk), .resetn(resetn), .start(start7), .single_mode(single7),
        .tile_x_in(tx7), .tile_y_in(ty7), .busy(busy7), .done(done7),
        .map_x(mx7), .map_y(my7), .sprite_type(spr7), .vga_plot(plot7),
        .vga_x(vx7), .vga_y(vy7), .vga_color(col7)
    );

    logic [2:0] mem  [0:31][0:31];
    logic [2:0] mem7 [0:31][0:31];
    always @(posedge clk) sprite_type <= mem[map_y][map_x];
    always @(posedge clk) spr7 <= mem7[my7][mx7];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int         cyc;
        int         x;
        int         y;
        logic [2:0] c;
    } ev_t;

    ev_t exp_q[$];
    int  op_id  = 0;
    int  op_s   = 0;
    int  op_d   = 0;
    bit  active = 1'b0;

    function automatic logic [2:0] golden(int typ, int px, int py, int ts);
        int c, dx, dy;
        c  = (ts - 1) / 2;
        dx = (px > c) ? px - c : c - px;
        dy = (py > c) ? py - c : c - py;
        case (typ)
            1:       return (dx + dy <= c) ? 3'b111 : 3'b000;
            2:       return (dx <= ts / 5 && dy <= ts / 5) ? 3'b111 : 3'b000;
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic add_tile(int s, int n, int tx, int ty);
        for (int py = 0; py < T; py++)
            for (int px = 0; px < T; px++)
                exp_q.push_back('{s + 3 + n * TPC + py * T + px, OX + tx * T + px,
                                  OY + ty * T + py, golden(int'(mem[ty][tx]), px, py, T)});
    endtask

    task automatic schedule(int s, bit single, int tx, int ty);
        int n = 0;
        exp_q.delete();
        if (!single) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    add_tile(s, n, x, y);
                    n++;
                end
        end else if (tx < W && ty < H) begin
            add_tile(s, 0, tx, ty);
            n = 1;
        end
        op_s   = s;
        op_d   = s + n * TPC + 1;
        active = 1'b1;
        op_id++;
    endtask

    int         plot_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int         last_done_cyc = 0, last_plot_cyc = 0;
    int         epoch = 0;
    int         seen_n  [0:159][0:119];
    int         seen_ep [0:159][0:119];
    logic [2:0] seen_col[0:159][0:119];
    int         plot7_cnt = 0, on7_cnt = 0, done7_cnt = 0;
    logic [2:0] img7    [0:127][0:127];

    initial begin
        int  rd  = 0;
        int  sid = 0;
        bit  ep, eb, ed;
        forever begin
            @(negedge clk);
            if (sid != op_id) begin
                rd  = 0;
                sid = op_id;
            end
            ep = (rd < exp_q.size()) && (exp_q[rd].cyc == cyc);
            eb = active && cyc >= op_s && cyc < op_d;
            ed = active && cyc == op_d;
            check("vga_plot", {31'b0, vga_plot}, {31'b0, ep});
            if (ep) begin
                check("vga_x", {24'b0, vga_x}, exp_q[rd].x);
                check("vga_y", {25'b0, vga_y}, exp_q[rd].y);
                check("vga_color", {29'b0, vga_color}, {29'b0, exp_q[rd].c});
                rd++;
            end
            check("busy", {31'b0, busy}, {31'b0, eb});
            check("done", {31'b0, done}, {31'b0, ed});

            if (vga_plot === 1'b1) begin
                plot_cnt++;
                last_plot_cyc = cyc;
                if (int'(vga_x) < 160 && int'(vga_y) < 120) begin
                    if (seen_ep[vga_x][vga_y] != epoch) begin
                        seen_ep[vga_x][vga_y] = epoch;
                        seen_n[vga_x][vga_y]  = 0;
                    end
                    seen_n[vga_x][vga_y]++;
                    seen_col[vga_x][vga_y] = vga_color;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (busy === 1'b1) busy_cnt++;
            if (plot7 === 1'b1) begin
                plot7_cnt++;
                if (vx7 < 8'd128) img7[vx7][vy7] = col7;
                if (col7 != 3'b000) on7_cnt++;
            end
            if (done7 === 1'b1) done7_cnt++;
        end
    end

    task automatic kick(input bit single, input int tx, input int ty, output int s);
        @(posedge clk); #1;
        start       = 1'b1;
        single_mode = single;
        tile_x_in   = 5'(tx);
        tile_y_in   = 5'(ty);
        @(posedge clk); #1;
        start = 1'b0;
        s     = cyc;
        schedule(s, single, tx, ty);
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    function automatic int coverage_bad(int x0, int x1, int y0, int y1);
        int bad = 0;
        for (int x = x0; x <= x1; x++)
            for (int y = y0; y <= y1; y++)
                if (seen_ep[x][y] != epoch || seen_n[x][y] != 1) bad++;
        return bad;
    endfunction

    initial begin
        int s, s7, p0, d0, b0, k;
        logic [4:0] mx0, my0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                mem[y][x]  = 3'((x + y) % 5);
                mem7[y][x] = 3'd0;
            end
        mem7[0][0] = 3'd1;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++) begin
                seen_ep[x][y] = 0;
                seen_n[x][y]  = 0;
            end
        resetn = 1'b0;
        start = 1'b0; single_mode = 1'b0; tile_x_in = '0; tile_y_in = '0;
        start7 = 1'b0; single7 = 1'b0; tx7 = '0; ty7 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_plot", {31'b0, vga_plot}, 0);
        check("rst_map_xy", {22'b0, map_x, map_y}, 0);
        check("rst_vga_xyc", {14'b0, vga_x, vga_y, vga_color}, 0);
        check("rst_dut7_busy_plot", {30'b0, busy7, plot7}, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Full frame over a (x+y)%5 checkerboard
        epoch = 1; p0 = plot_cnt; d0 = done_cnt;
        kick(1'b0, 0, 0, s);
        wait_until(op_d + 2);
        check("t1_plot_count", plot_cnt - p0, 11025);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_coverage_bad", coverage_bad(1, 105, 1, 105), 0);
        check("t1_start_to_done", last_done_cyc - (s - 1), 441 * 27 + 2);
        check("t1_done_after_last_plot", last_done_cyc - last_plot_cyc, 1);
        check("t1_empty_px", {29'b0, seen_col[1][1]}, 0);
        check("t1_bigorb_centre", {29'b0, seen_col[8][3]}, 7);
        check("t1_bigorb_corner", {29'b0, seen_col[6][1]}, 0);
        check("t1_smallorb_on", {29'b0, seen_col[12][2]}, 7);
        check("t1_smallorb_off", {29'b0, seen_col[11][3]}, 0);
        check("t1_wall", {29'b0, seen_col[16][1]}, 1);
        check("t1_door", {29'b0, seen_col[21][1]}, 2);

        // Single WALL tile at (3,4)
        mem[4][3] = 3'd3;
        epoch = 2; p0 = plot_cnt; d0 = done_cnt; b0 = busy_cnt;
        kick(1'b1, 3, 4, s);
        wait_until(op_d + 2);
        check("t2_plot_count", plot_cnt - p0, 25);
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_busy_cycles", busy_cnt - b0, 28);
        check("t2_coverage_bad", coverage_bad(16, 20, 21, 25), 0);
        check("t2_colour_first", {29'b0, seen_col[16][21]}, 1);
        check("t2_colour_last", {29'b0, seen_col[20][25]}, 1);

        // Single tile out of range
        mx0 = map_x; my0 = map_y; p0 = plot_cnt; d0 = done_cnt;
        kick(1'b1, 21, 0, s);
        wait_until(op_d + 2);
        check("t3_plot_count", plot_cnt - p0, 0);
        check("t3_done_count", done_cnt - d0, 1);
        check("t3_start_to_done", last_done_cyc - (s - 1), 2);
        check("t3_map_xy_held", {22'b0, map_x, map_y}, {22'b0, mx0, my0});
        check("t3_map_xy_value", {22'b0, map_x, map_y}, {22'b0, 5'd3, 5'd4});

        // start held high for the whole frame
        p0 = plot_cnt; d0 = done_cnt;
        kick(1'b0, 0, 0, s);
        while (cyc < op_d) begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_until(op_d + 3);
        check("t4_plot_count", plot_cnt - p0, 11025);
        check("t4_done_count", done_cnt - d0, 1);

        // Reset mid-frame at plot #300
        p0 = plot_cnt; d0 = done_cnt;
        kick(1'b0, 0, 0, s);
        k = 0;
        while (plot_cnt - p0 < 300 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_reached_plot_300", plot_cnt - p0, 300);
        resetn = 1'b0;
        active = 1'b0;
        exp_q.delete();
        op_id++;
        #1;
        check("t5_async_plot", {31'b0, vga_plot}, 0);
        check("t5_async_busy", {31'b0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", done_cnt - d0, 0);
        epoch = 5; p0 = plot_cnt; d0 = done_cnt;
        kick(1'b0, 0, 0, s);
        wait_until(op_d + 2);
        check("t5_redraw_plot_count", plot_cnt - p0, 11025);
        check("t5_redraw_coverage_bad", coverage_bad(1, 105, 1, 105), 0);
        check("t5_redraw_done_count", done_cnt - d0, 1);

        // TILE_SIZE=7 BIG_ORB diamond on the second instance
        @(posedge clk); #1;
        start7 = 1'b1; single7 = 1'b1; tx7 = 5'd0; ty7 = 5'd0;
        @(posedge clk); #1;
        start7 = 1'b0;
        s7 = cyc;
        wait_until(s7 + 60);
        check("t6_plot_count", plot7_cnt, 49);
        check("t6_on_count", on7_cnt, 25);
        check("t6_done_count", done7_cnt, 1);
        check("t6_centre", {29'b0, img7[4][4]}, 7);
        check("t6_top", {29'b0, img7[4][1]}, 7);
        check("t6_left", {29'b0, img7[1][4]}, 7);
        check("t6_right", {29'b0, img7[7][4]}, 7);
        check("t6_inner", {29'b0, img7[3][3]}, 7);
        check("t6_corner", {29'b0, img7[1][1]}, 0);
        check("t6_outside_diamond", {29'b0, img7[2][2]}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
